// File: rtl/idex_hazard_if.sv
// rtl/idex_hazard_if.sv - ID/EX stage bus: decoded ID fields in, registered EX fields and hazard controls out
interface idex_hazard_if #(
  parameter int CNT_W = 16
);
  // ID-side fields
  logic [4:0]       IFID_rs;
  logic [4:0]       IFID_rt;
  logic [4:0]       IFID_rd;
  logic             id_valid;
  logic             id_regWrite;
  logic             id_memRead;
  logic             id_memWrite;
  logic             id_memtoReg;
  logic             id_aluSrc;
  logic [3:0]       id_aluOp;
  logic [31:0]      id_readData1;
  logic [31:0]      id_readData2;
  logic [31:0]      id_imm;
  logic             branch_taken;

  // EX-side registered fields
  logic [4:0]       IDEX_rs;
  logic [4:0]       IDEX_rt;
  logic [4:0]       IDEX_rd;
  logic             IDEX_valid;
  logic             IDEX_regWrite;
  logic             IDEX_memRead;
  logic             IDEX_memWrite;
  logic             IDEX_memtoReg;
  logic             IDEX_aluSrc;
  logic [3:0]       IDEX_aluOp;
  logic [31:0]      IDEX_readData1;
  logic [31:0]      IDEX_readData2;
  logic [31:0]      IDEX_imm;

  // Hazard controls and statistics
  logic             pcWrite;
  logic             IFIDWrite;
  logic             stall;
  logic [CNT_W-1:0] stall_count;
  logic [CNT_W-1:0] flush_count;

  // Decode/fetch side: drives ID fields, observes EX fields and hazard controls
  modport master (
    output IFID_rs, IFID_rt, IFID_rd, id_valid, id_regWrite, id_memRead, id_memWrite,
           id_memtoReg, id_aluSrc, id_aluOp, id_readData1, id_readData2, id_imm, branch_taken,
    input  IDEX_rs, IDEX_rt, IDEX_rd, IDEX_valid, IDEX_regWrite, IDEX_memRead, IDEX_memWrite,
           IDEX_memtoReg, IDEX_aluSrc, IDEX_aluOp, IDEX_readData1, IDEX_readData2, IDEX_imm,
           pcWrite, IFIDWrite, stall, stall_count, flush_count
  );

  // The ID/EX stage itself
  modport slave (
    input  IFID_rs, IFID_rt, IFID_rd, id_valid, id_regWrite, id_memRead, id_memWrite,
           id_memtoReg, id_aluSrc, id_aluOp, id_readData1, id_readData2, id_imm, branch_taken,
    output IDEX_rs, IDEX_rt, IDEX_rd, IDEX_valid, IDEX_regWrite, IDEX_memRead, IDEX_memWrite,
           IDEX_memtoReg, IDEX_aluSrc, IDEX_aluOp, IDEX_readData1, IDEX_readData2, IDEX_imm,
           pcWrite, IFIDWrite, stall, stall_count, flush_count
  );
endinterface

// File: rtl/idex_hazard_stage.sv
// rtl/idex_hazard_stage.sv - ID/EX pipeline register with load-use stall and branch flush
module idex_hazard_stage #(
  parameter int LOAD_USE_BUBBLES = 1,   // 1..3 bubbles per load-use hazard
  parameter bit MEM_FWD_EN       = 1'b1,
  parameter int CNT_W            = 16
) (
  input  logic           clk,
  input  logic           reset,
  idex_hazard_if.slave   bus
);

  typedef enum logic {S_RUN, S_STALL} state_t;

  typedef struct packed {
    logic        valid;
    logic        regWrite;
    logic        memRead;
    logic        memWrite;
    logic        memtoReg;
    logic        aluSrc;
    logic [3:0]  aluOp;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [31:0] readData1;
    logic [31:0] readData2;
    logic [31:0] imm;
  } idex_t;

  // Bubbles still owed after the first one, loaded on entry to STALL
  localparam logic [1:0] REM_INIT =
    (LOAD_USE_BUBBLES > 1) ? 2'(LOAD_USE_BUBBLES - 2) : 2'd0;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state_q, state_d;
  logic [1:0]       rem_q, rem_d;
  idex_t            idex_q, idex_d;
  idex_t            id_fields;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic             hz;
  logic             rt_dep;
  logic             stall_w;
  logic             pc_write_w;

  // A bubble kills the instruction and its register ids; data fields are don't-care and simply hold
  function automatic idex_t bubble(input idex_t cur);
    idex_t b;
    b          = cur;
    b.valid    = 1'b0;
    b.regWrite = 1'b0;
    b.memRead  = 1'b0;
    b.memWrite = 1'b0;
    b.memtoReg = 1'b0;
    b.aluSrc   = 1'b0;
    b.aluOp    = 4'd0;
    b.rs       = 5'd0;
    b.rt       = 5'd0;
    b.rd       = 5'd0;
    return b;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == CNT_MAX) ? c : c + CNT_W'(1);
  endfunction

  assign id_fields = '{
    valid:     bus.id_valid,
    regWrite:  bus.id_regWrite,
    memRead:   bus.id_memRead,
    memWrite:  bus.id_memWrite,
    memtoReg:  bus.id_memtoReg,
    aluSrc:    bus.id_aluSrc,
    aluOp:     bus.id_aluOp,
    rs:        bus.IFID_rs,
    rt:        bus.IFID_rt,
    rd:        bus.IFID_rd,
    readData1: bus.id_readData1,
    readData2: bus.id_readData2,
    imm:       bus.id_imm
  };

  // An rt match only matters when the ID instruction is not a store whose data the MEM stage can forward
  assign rt_dep = (idex_q.rt == bus.IFID_rt) && !(MEM_FWD_EN && bus.id_memWrite);

  // Load in EX whose destination is read by the real instruction in ID ($0 never hazards)
  assign hz = idex_q.valid && idex_q.memRead && (idex_q.rt != 5'd0) && bus.id_valid &&
              ((idex_q.rt == bus.IFID_rs) || rt_dep);

  // Next-state and hazard outputs: branch flush beats stall beats normal advance
  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    idex_d      = idex_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    stall_w     = 1'b0;
    pc_write_w  = 1'b1;
    if (reset) begin
      pc_write_w = 1'b0;
    end else if (bus.branch_taken) begin
      idex_d      = bubble(idex_q);
      state_d     = S_RUN;
      rem_d       = 2'd0;
      flush_cnt_d = sat_inc(flush_cnt_q);
    end else if ((state_q == S_RUN && hz) || state_q == S_STALL) begin
      stall_w     = 1'b1;
      pc_write_w  = 1'b0;
      idex_d      = bubble(idex_q);
      stall_cnt_d = sat_inc(stall_cnt_q);
      if (state_q == S_RUN) begin
        if (LOAD_USE_BUBBLES > 1) begin
          state_d = S_STALL;
          rem_d   = REM_INIT;
        end
      end else if (rem_q == 2'd0) begin
        state_d = S_RUN;
      end else begin
        rem_d = rem_q - 2'd1;
      end
    end else begin
      idex_d = id_fields;
    end
  end

  // State, pipeline register and statistics counters
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_RUN;
      rem_q       <= 2'd0;
      idex_q      <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      idex_q      <= idex_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign bus.IDEX_rs        = idex_q.rs;
  assign bus.IDEX_rt        = idex_q.rt;
  assign bus.IDEX_rd        = idex_q.rd;
  assign bus.IDEX_valid     = idex_q.valid;
  assign bus.IDEX_regWrite  = idex_q.regWrite;
  assign bus.IDEX_memRead   = idex_q.memRead;
  assign bus.IDEX_memWrite  = idex_q.memWrite;
  assign bus.IDEX_memtoReg  = idex_q.memtoReg;
  assign bus.IDEX_aluSrc    = idex_q.aluSrc;
  assign bus.IDEX_aluOp     = idex_q.aluOp;
  assign bus.IDEX_readData1 = idex_q.readData1;
  assign bus.IDEX_readData2 = idex_q.readData2;
  assign bus.IDEX_imm       = idex_q.imm;
  assign bus.stall          = stall_w;
  assign bus.pcWrite        = pc_write_w;
  assign bus.IFIDWrite      = pc_write_w;
  assign bus.stall_count    = stall_cnt_q;
  assign bus.flush_count    = flush_cnt_q;

endmodule
